// File: rtl/sample_buf_pkg.sv
// -----------------------------------------------------------------------------
// sample_buf_pkg
// Shared constants for the logic-analyser capture buffer.
//   DEPTH_DEFAULT  : default number of capture words
//   ADDR_W_DEFAULT : default pointer width (log2 of DEPTH_DEFAULT)
//   COUNT_W        : width of the occupancy / overflow count outputs
//   DATA_W         : width of one probe sample
// -----------------------------------------------------------------------------
package sample_buf_pkg;

  localparam int DEPTH_DEFAULT  = 4096;
  localparam int ADDR_W_DEFAULT = 12;
  localparam int COUNT_W        = 16;
  localparam int DATA_W         = 8;

endpackage : sample_buf_pkg

// File: rtl/sample_buf_ram.sv
// -----------------------------------------------------------------------------
// sample_buf_ram
// Simple dual-port capture memory: one write port, one registered read port,
// DATA_W x DEPTH. Shaped so synthesis maps it onto block RAM. A read of the
// address being written in the same cycle returns the old contents.
//
// Ports
//   clk    : clock, rising edge
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address, sampled on the rising edge
//   rdata  : registered read data (one cycle after raddr)
// -----------------------------------------------------------------------------
module sample_buf_ram
  import sample_buf_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset; a reset would stop it mapping to block RAM,
  // and stale contents are never observed because the pointers are reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule : sample_buf_ram

// File: rtl/sample_buffer.sv
// -----------------------------------------------------------------------------
// sample_buffer
// Show-ahead capture FIFO for a logic-analyser probe. data_out always presents
// the oldest unread word so the controller can sample it in the same cycle it
// asserts read_en. Pointers, occupancy, flags and the empty-push bypass live
// here; storage lives in sample_buf_ram.
//
// Optional feature: define SAMPLE_BUF_OVF_EN to add the overflow (sticky) and
// ovf_count (saturating count of dropped pushes) outputs.
//
// Ports
//   clk          : sole clock, rising edge
//   resetn       : synchronous active-low reset (same effect as clear)
//   sample_data  : probe sample, valid every cycle
//   write_en     : push sample_data (ignored while full)
//   read_en      : pop the word on data_out (ignored while empty)
//   clear        : discard all contents; overrides write_en/read_en
//   full         : occupancy == DEPTH (registered)
//   empty        : occupancy == 0 (registered)
//   sample_count : occupancy, zero-extended to COUNT_W
//   overflow     : [SAMPLE_BUF_OVF_EN] sticky, set by any dropped push
//   ovf_count    : [SAMPLE_BUF_OVF_EN] dropped pushes, saturating
//   data_out     : oldest unread word, valid while empty = 0, 0 when empty
// -----------------------------------------------------------------------------
module sample_buffer
  import sample_buf_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [DATA_W-1:0]  sample_data,
  input  logic               write_en,
  input  logic               read_en,
  input  logic               clear,
  output logic               full,
  output logic               empty,
  output logic [COUNT_W-1:0] sample_count,
`ifdef SAMPLE_BUF_OVF_EN
  output logic               overflow,
  output logic [COUNT_W-1:0] ovf_count,
`endif
  output logic [DATA_W-1:0]  data_out
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_nxt;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_nxt;
  logic [ADDR_W:0]   count_q, count_nxt;
  logic              push_ok, pop_ok;
  logic              byp_nxt, byp_q;
  logic [DATA_W-1:0] byp_data_q;
  logic [DATA_W-1:0] ram_rdata;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    push_ok    = resetn && !clear && write_en && !full;
    pop_ok     = resetn && !clear && read_en && !empty;
    wr_ptr_nxt = wr_ptr_q + ADDR_W'(push_ok);
    rd_ptr_nxt = rd_ptr_q + ADDR_W'(pop_ok);
    count_nxt  = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_nxt = count_q + 1'b1;
      2'b01:   count_nxt = count_q - 1'b1;
      default: count_nxt = count_q;
    endcase
    if (clear) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end
    // The RAM returns old data when the word written this cycle is the one
    // that must be shown next cycle (push into empty, or push+pop at one word),
    // so that word is taken from a bypass register instead.
    byp_nxt = push_ok && (wr_ptr_q == rd_ptr_nxt);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      byp_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_nxt;
      rd_ptr_q <= rd_ptr_nxt;
      count_q  <= count_nxt;
      full     <= (count_nxt == FULL_COUNT);
      empty    <= (count_nxt == '0);
      byp_q    <= byp_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (byp_nxt) begin
      byp_data_q <= sample_data;
    end
  end

  // Read address is the next read pointer so the registered RAM output lines
  // up with the pointer on the following cycle.
  sample_buf_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr_q),
    .wdata (sample_data),
    .raddr (rd_ptr_nxt),
    .rdata (ram_rdata)
  );

  assign data_out     = empty ? '0 : (byp_q ? byp_data_q : ram_rdata);
  assign sample_count = COUNT_W'(count_q);

`ifdef SAMPLE_BUF_OVF_EN
  logic drop;

  assign drop = write_en && full && !clear;

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      overflow  <= 1'b0;
      ovf_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (ovf_count != '1) begin
        ovf_count <= ovf_count + 1'b1;
      end
    end
  end
`endif

endmodule : sample_buffer

// File: tb/tb_sample_buffer.sv
// -----------------------------------------------------------------------------
// tb_sample_buffer
// Scoreboard bench for sample_buffer with DEPTH=16. The driver pushes each
// word it expects to be accepted onto exp_q; a monitor on the falling edge
// compares data_out, empty and sample_count against the queue and pops the
// head whenever read_en is presented on a non-empty buffer. Flag values at
// the key points are also checked against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_sample_buffer;
  import sample_buf_pkg::*;

  localparam int TB_DEPTH  = 16;
  localparam int TB_ADDR_W = 4;

  logic               clk = 1'b0;
  logic               resetn;
  logic [DATA_W-1:0]  sample_data;
  logic               write_en;
  logic               read_en;
  logic               clear;
  logic               full;
  logic               empty;
  logic [COUNT_W-1:0] sample_count;
  logic [DATA_W-1:0]  data_out;
`ifdef SAMPLE_BUF_OVF_EN
  logic               overflow;
  logic [COUNT_W-1:0] ovf_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W-1:0] exp_q [$];

  always #5 clk = ~clk;

  sample_buffer #(
    .DEPTH  (TB_DEPTH),
    .ADDR_W (TB_ADDR_W)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .sample_data  (sample_data),
    .write_en     (write_en),
    .read_en      (read_en),
    .clear        (clear),
    .full         (full),
    .empty        (empty),
    .sample_count (sample_count),
`ifdef SAMPLE_BUF_OVF_EN
    .overflow     (overflow),
    .ovf_count    (ovf_count),
`endif
    .data_out     (data_out)
  );

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    write_en    = 1'b0;
    read_en     = 1'b0;
    clear       = 1'b0;
    sample_data = '0;
  endtask

  // One clock of stimulus; exp_push says whether this push should be accepted.
  task automatic step(input logic we, input logic [DATA_W-1:0] d, input logic re,
                      input logic clr, input bit exp_push);
    write_en    = we;
    sample_data = d;
    read_en     = re;
    clear       = clr;
    @(posedge clk);
    #1;
    if (clr) exp_q.delete();
    else if (exp_push) exp_q.push_back(d);
    idle();
  endtask

  // Monitor: compare the show-ahead word and flags, pop on a handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (resetn) begin
        check("mon_empty", empty, (exp_q.size() == 0));
        check("mon_count", sample_count, exp_q.size());
        if (!empty) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL mon_data: actual=0x%0h required=no word at %0t", data_out, $time);
          end else begin
            check("mon_data", data_out, exp_q[0]);
            if (read_en) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    n_checks++;
    n_errors++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    idle();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_count", sample_count, 0);
    check("rst_data", data_out, 0);

    // Push three words; the first is bypassed onto data_out as empty falls.
    step(1, 8'h11, 0, 0, 1);
    check("push1_empty", empty, 0);
    check("push1_data", data_out, 8'h11);
    step(1, 8'h22, 0, 0, 1);
    step(1, 8'h33, 0, 0, 1);
    check("push3_count", sample_count, 3);

    // Pop three, then a pop on empty is ignored.
    repeat (3) step(0, 8'h00, 1, 0, 0);
    check("pop3_empty", empty, 1);
    check("pop3_count", sample_count, 0);
    step(0, 8'h00, 1, 0, 0);
    check("pop_empty_count", sample_count, 0);
    check("pop_empty_empty", empty, 1);

    // Push and pop on empty: only the push lands.
    step(1, 8'h5C, 1, 0, 1);
    check("both_empty_count", sample_count, 1);
    check("both_empty_data", data_out, 8'h5C);
    step(0, 8'h00, 1, 0, 0);

    // Fill to DEPTH, then one dropped push.
    for (int i = 0; i < 16; i++) step(1, 8'(8'h40 + i), 0, 0, 1);
    check("fill_full", full, 1);
    check("fill_count", sample_count, 16);
    step(1, 8'h50, 0, 0, 0);
    check("drop_full", full, 1);
    check("drop_count", sample_count, 16);
`ifdef SAMPLE_BUF_OVF_EN
    check("drop_overflow", overflow, 1);
    check("drop_ovf_count", ovf_count, 1);
`endif

    // Push and pop while full: only the pop lands.
    step(1, 8'h99, 1, 0, 0);
    check("both_full_count", sample_count, 15);
    check("both_full_full", full, 0);
`ifdef SAMPLE_BUF_OVF_EN
    check("both_full_ovf_count", ovf_count, 2);
`endif

    // Drain to five words, then stream ten push+pop cycles across the wrap.
    repeat (10) step(0, 8'h00, 1, 0, 0);
    check("hold5_count", sample_count, 5);
    for (int i = 0; i < 10; i++) begin
      step(1, 8'(8'h60 + i), 1, 0, 1);
      check("stream_count", sample_count, 5);
    end

    // Eight words held, clear during a push+pop.
    for (int i = 0; i < 3; i++) step(1, 8'(8'h70 + i), 0, 0, 1);
    check("hold8_count", sample_count, 8);
    step(1, 8'h77, 1, 1, 0);
    check("clr_empty", empty, 1);
    check("clr_full", full, 0);
    check("clr_count", sample_count, 0);
    check("clr_data", data_out, 0);
`ifdef SAMPLE_BUF_OVF_EN
    check("clr_overflow", overflow, 0);
    check("clr_ovf_count", ovf_count, 0);
`endif
    step(1, 8'hA5, 0, 0, 1);
    check("post_clr_data", data_out, 8'hA5);
    check("post_clr_count", sample_count, 1);

    // Push+pop with one word held: new word must appear next cycle.
    step(1, 8'hC3, 1, 0, 1);
    check("both_one_count", sample_count, 1);
    check("both_one_data", data_out, 8'hC3);

    // Fill again (pointers wrap past DEPTH) and reset while full.
    for (int i = 0; i < 15; i++) step(1, 8'(8'hB0 + i), 0, 0, 1);
    check("refill_full", full, 1);
`ifdef SAMPLE_BUF_OVF_EN
    step(1, 8'hEE, 0, 0, 0);
    check("refill_ovf_count", ovf_count, 1);
`endif
    resetn      = 1'b0;
    write_en    = 1'b1;
    read_en     = 1'b1;
    sample_data = 8'hDD;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    idle();
    exp_q.delete();
    check("rst_mid_full", full, 0);
    check("rst_mid_empty", empty, 1);
    check("rst_mid_count", sample_count, 0);
    check("rst_mid_data", data_out, 0);
`ifdef SAMPLE_BUF_OVF_EN
    check("rst_mid_ovf_count", ovf_count, 0);
`endif

    step(1, 8'h5A, 0, 0, 1);
    check("post_rst_data", data_out, 8'h5A);
    step(0, 8'h00, 1, 0, 0);
    check("post_rst_empty", empty, 1);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_sample_buffer
